// File: rtl/ps2_receive.sv
// Host-side PS/2 receiver: conditions the device-driven PS2C/PS2D lines and
// decodes 11-bit device-to-host frames, reporting bytes and frame errors.
module ps2_receive #(
  parameter int unsigned FILTER_LEN     = 8,
  parameter int unsigned TIMEOUT_CYCLES = 5000
) (
  input  logic       qzt_clk,
  input  logic       reset,
  input  logic       PS2C,
  input  logic       PS2D,
  input  logic       inhibit,
  output logic [7:0] data,
  output logic       data_valid,
  output logic       err,
  output logic [1:0] err_code,
  output logic       busy
);

  localparam int unsigned FCW = 4;
  localparam int unsigned BCW = 4;
  localparam int unsigned TCW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [FCW-1:0] FILT_LAST = FCW'(FILTER_LEN - 1);
  localparam logic [TCW-1:0] TO_LAST   = TCW'(TIMEOUT_CYCLES - 1);

  localparam logic [1:0] CODE_PARITY  = 2'b01;
  localparam logic [1:0] CODE_STOP    = 2'b10;
  localparam logic [1:0] CODE_TIMEOUT = 2'b11;

  typedef enum logic {
    IDLE,
    RECV
  } state_t;

  // Line conditioning; index 0 is PS2C, index 1 is PS2D.
  logic [1:0]     raw;
  logic [1:0]     sync1;
  logic [1:0]     sync2;
  logic [1:0]     filt;
  logic [1:0]     filt_prev;
  logic [FCW-1:0] fcnt [2];

  assign raw = {PS2D, PS2C};

  always_ff @(posedge qzt_clk) begin
    if (reset) begin
      sync1     <= '1;
      sync2     <= '1;
      filt      <= '1;
      filt_prev <= '1;
      for (int i = 0; i < 2; i++) begin
        fcnt[i] <= '0;
      end
    end else begin
      sync1     <= raw;
      sync2     <= sync1;
      filt_prev <= filt;
      for (int i = 0; i < 2; i++) begin
        if (sync2[i] == filt[i]) begin
          fcnt[i] <= '0;
        end else if (fcnt[i] == FILT_LAST) begin
          filt[i] <= sync2[i];
          fcnt[i] <= '0;
        end else begin
          fcnt[i] <= fcnt[i] + FCW'(1);
        end
      end
    end
  end

  logic fall_c;
  logic din_c;

  assign fall_c = filt_prev[0] & ~filt[0];
  assign din_c  = filt[1];

  // Frame decoder state
  state_t         state_q;
  state_t         state_d;
  logic [BCW-1:0] bit_cnt_q;
  logic [BCW-1:0] bit_cnt_d;
  logic [7:0]     shift_q;
  logic [7:0]     shift_d;
  logic           parity_q;
  logic           parity_d;
  logic [TCW-1:0] tcnt_q;
  logic [TCW-1:0] tcnt_d;
  logic [TCW-1:0] tcnt_inc;
  logic [7:0]     data_d;
  logic           valid_d;
  logic           err_d;
  logic [1:0]     code_d;
  logic           busy_d;

  assign tcnt_inc = tcnt_q + TCW'(1);

  always_ff @(posedge qzt_clk) begin
    if (reset) begin
      state_q    <= IDLE;
      bit_cnt_q  <= '0;
      shift_q    <= '0;
      parity_q   <= 1'b0;
      tcnt_q     <= '0;
      data       <= '0;
      data_valid <= 1'b0;
      err        <= 1'b0;
      err_code   <= '0;
      busy       <= 1'b0;
    end else begin
      state_q    <= state_d;
      bit_cnt_q  <= bit_cnt_d;
      shift_q    <= shift_d;
      parity_q   <= parity_d;
      tcnt_q     <= tcnt_d;
      data       <= data_d;
      data_valid <= valid_d;
      err        <= err_d;
      err_code   <= code_d;
      busy       <= busy_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    bit_cnt_d = bit_cnt_q;
    shift_d   = shift_q;
    parity_d  = parity_q;
    tcnt_d    = tcnt_q;
    data_d    = data;
    valid_d   = 1'b0;
    err_d     = 1'b0;
    code_d    = err_code;

    if (inhibit) begin
      // Transmitter owns the bus: drop any partial frame without reporting.
      state_d   = IDLE;
      bit_cnt_d = '0;
      shift_d   = '0;
      parity_d  = 1'b0;
      tcnt_d    = '0;
    end else begin
      case (state_q)
        IDLE: begin
          tcnt_d = '0;
          if (fall_c && !din_c) begin
            state_d   = RECV;
            bit_cnt_d = BCW'(1);
            shift_d   = '0;
            parity_d  = 1'b0;
          end
        end
        RECV: begin
          if (fall_c) begin
            tcnt_d    = '0;
            bit_cnt_d = bit_cnt_q + BCW'(1);
            if (bit_cnt_q <= BCW'(8)) begin
              shift_d = {din_c, shift_q[7:1]};
            end else if (bit_cnt_q == BCW'(9)) begin
              parity_d = din_c;
            end else begin
              // Stop bit: stop framing outranks parity.
              state_d   = IDLE;
              bit_cnt_d = '0;
              if (!din_c) begin
                err_d  = 1'b1;
                code_d = CODE_STOP;
              end else if (^{shift_q, parity_q} == 1'b0) begin
                err_d  = 1'b1;
                code_d = CODE_PARITY;
              end else begin
                data_d  = shift_q;
                valid_d = 1'b1;
              end
            end
          end else if (tcnt_inc == TO_LAST) begin
            state_d   = IDLE;
            bit_cnt_d = '0;
            shift_d   = '0;
            parity_d  = 1'b0;
            tcnt_d    = '0;
            err_d     = 1'b1;
            code_d    = CODE_TIMEOUT;
          end else begin
            tcnt_d = tcnt_inc;
          end
        end
        default: state_d = IDLE;
      endcase
    end

    busy_d = (state_d == RECV);
  end

endmodule
